fetch_pc_ctrl: RTL and testbench

- Owns the architectural fetch PC and sequences instruction fetch over a single-outstanding request/response instruction-memory port.
- Consumes the EX-stage next-PC decision (sequential, branch, jal, jalr) and on redirect:
  - flushes IF/ID and ID/EX;
  - discards any in-flight wrong-path fetch.
- Honours load-use stalls from hazard detection.
- Sits between the instruction memory and the IF/ID pipeline register.

---
 rtl/fetch_pc_ctrl_if.sv | 13 +
 rtl/fetch_pc_ctrl.sv | 118 +++++++++++
 tb/tb_fetch_pc_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_ctrl_if.sv
// rtl/fetch_pc_ctrl_if.sv - single-outstanding instruction-memory request/response port
interface fetch_pc_ctrl_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            ready;
    logic            rvalid;
    logic [31:0]     rdata;

    modport master (output req, output addr, input ready, input rvalid, input rdata);
    modport slave  (input req, input addr, output ready, output rvalid, output rdata);
endinterface

// File: rtl/fetch_pc_ctrl.sv
// rtl/fetch_pc_ctrl.sv - fetch PC owner and instruction-fetch sequencer feeding IF/ID
module fetch_pc_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ex_valid,
    input  logic [2:0]        ex_next_pc_op,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic [XLEN-1:0]   ex_imm,
    input  logic [XLEN-1:0]   ex_alu_result,
    input  logic              hazard_stall,
    fetch_pc_ctrl_if.master   imem,
    output logic              if_valid,
    output logic [XLEN-1:0]   if_pc,
    output logic [31:0]       if_instr,
    output logic              ifid_flush,
    output logic              idex_flush
);
    typedef enum logic [1:0] {BOOT, REQ, WAIT, DISCARD} state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inflight_pc;
    logic            buf_valid;
    logic [XLEN-1:0] buf_pc;
    logic [31:0]     buf_instr;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            accept;
    logic            resp;

    always_comb begin
        redirect = ex_valid && (ex_next_pc_op == 3'b001 || ex_next_pc_op == 3'b010 ||
                                ex_next_pc_op == 3'b011);
        if (ex_next_pc_op == 3'b011)
            target = ex_alu_result & ~XLEN'(1);
        else
            target = ex_pc + ex_imm;
    end

    assign ifid_flush = redirect;
    assign idex_flush = redirect;

    // A full buffer means nowhere to land a response, so no new request goes out.
    assign imem.req  = (state == REQ) && !buf_valid;
    assign imem.addr = pc;
    assign accept    = imem.req && imem.ready;
    assign resp      = (state == WAIT) && imem.rvalid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            inflight_pc <= RESET_PC;
            buf_valid   <= 1'b0;
            buf_pc      <= '0;
            buf_instr   <= 32'h0000_0013;
            if_valid    <= 1'b0;
            if_pc       <= '0;
            if_instr    <= 32'h0000_0013;
        end else if (redirect) begin
            pc        <= target;
            buf_valid <= 1'b0;
            if_valid  <= 1'b0;
            case (state)
                BOOT:    state <= REQ;
                REQ:     state <= accept ? DISCARD : REQ;
                WAIT:    state <= imem.rvalid ? REQ : DISCARD;
                DISCARD: state <= imem.rvalid ? REQ : DISCARD;
                default: state <= REQ;
            endcase
        end else begin
            case (state)
                BOOT: state <= REQ;
                REQ: begin
                    if (accept) begin
                        inflight_pc <= pc;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem.rvalid) begin
                        pc    <= pc + XLEN'(4);
                        state <= REQ;
                    end
                end
                DISCARD: begin
                    if (imem.rvalid)
                        state <= REQ;
                end
                default: state <= BOOT;
            endcase

            // Requests only issue with an empty buffer, so a response never meets a full one.
            if (!hazard_stall) begin
                if (resp) begin
                    if_valid <= 1'b1;
                    if_pc    <= inflight_pc;
                    if_instr <= imem.rdata;
                end else if (buf_valid) begin
                    if_valid  <= 1'b1;
                    if_pc     <= buf_pc;
                    if_instr  <= buf_instr;
                    buf_valid <= 1'b0;
                end else begin
                    if_valid <= 1'b0;
                end
            end else if (resp) begin
                buf_valid <= 1'b1;
                buf_pc    <= inflight_pc;
                buf_instr <= imem.rdata;
            end
        end
    end
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb/tb_fetch_pc_ctrl.sv - self-checking bench for fetch_pc_ctrl with a one-cycle-latency memory
module tb_fetch_pc_ctrl;
    logic        clk = 1'b0;
    logic        rstn;
    logic        ex_valid;
    logic [2:0]  ex_next_pc_op;
    logic [31:0] ex_pc, ex_imm, ex_alu_result;
    logic        hazard_stall;
    logic        if_valid;
    logic [31:0] if_pc, if_instr;
    logic        ifid_flush, idex_flush;
    logic        mem_ready;

    fetch_pc_ctrl_if #(.XLEN(32)) imem ();

    fetch_pc_ctrl #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .ex_valid      (ex_valid),
        .ex_next_pc_op (ex_next_pc_op),
        .ex_pc         (ex_pc),
        .ex_imm        (ex_imm),
        .ex_alu_result (ex_alu_result),
        .hazard_stall  (hazard_stall),
        .imem          (imem),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_instr      (if_instr),
        .ifid_flush    (ifid_flush),
        .idex_flush    (idex_flush)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0010_0093 : {a[23:0], 8'h13};
    endfunction

    // Memory: accepts whenever mem_ready, answers exactly one cycle later.
    logic        pending;
    logic [31:0] paddr;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending <= 1'b0;
            paddr   <= '0;
        end else begin
            pending <= imem.req && imem.ready;
            if (imem.req && imem.ready)
                paddr <= imem.addr;
        end
    end
    assign imem.ready  = mem_ready;
    assign imem.rvalid = pending;
    assign imem.rdata  = pending ? instr_of(paddr) : 32'h0;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] addr_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wait_req(input bit use_addr, input logic [31:0] a, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (imem.req && (!use_addr || imem.addr == a)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_if(input logic [31:0] a, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (if_valid && if_pc == a) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic drive_ex(input logic v, input logic [2:0] op, input logic [31:0] p,
                            input logic [31:0] imm, input logic [31:0] alu);
        ex_valid      = v;
        ex_next_pc_op = op;
        ex_pc         = p;
        ex_imm        = imm;
        ex_alu_result = alu;
    endtask

    typedef struct {
        logic        v;
        logic [2:0]  op;
        logic [31:0] p;
        logic [31:0] imm;
        logic [31:0] alu;
        logic        exp_flush;
        logic [31:0] exp_target;
    } vec_t;

    vec_t vec[9];

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        bit          ok;
        logic [31:0] a;
        int          cnt;

        vec[0] = '{1'b1, 3'b001, 32'h40,        32'h20,        32'h0,    1'b1, 32'h60};
        vec[1] = '{1'b1, 3'b010, 32'h100,       32'hFFFF_FFF0, 32'h0,    1'b1, 32'hF0};
        vec[2] = '{1'b1, 3'b011, 32'h0,         32'h0,         32'h1235, 1'b1, 32'h1234};
        vec[3] = '{1'b1, 3'b000, 32'h500,       32'h40,        32'h0,    1'b0, 32'h0};
        vec[4] = '{1'b1, 3'b100, 32'h500,       32'h40,        32'h0,    1'b0, 32'h0};
        vec[5] = '{1'b1, 3'b111, 32'h500,       32'h40,        32'h77,   1'b0, 32'h0};
        vec[6] = '{1'b1, 3'b001, 32'hFFFF_FFF0, 32'h20,        32'h0,    1'b1, 32'h10};
        vec[7] = '{1'b1, 3'b010, 32'h200,       32'h6,         32'h0,    1'b1, 32'h206};
        vec[8] = '{1'b0, 3'b001, 32'h40,        32'h20,        32'h0,    1'b0, 32'h0};

        rstn = 1'b0;
        mem_ready = 1'b1;
        hazard_stall = 1'b0;
        drive_ex(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        chk("rst_req", imem.req, 0);
        chk("rst_addr", imem.addr, 32'h0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0000_0013);
        chk("rst_ifid_flush", ifid_flush, 0);
        chk("rst_idex_flush", idex_flush, 0);

        // First fetch after reset release
        rstn = 1'b1;
        #1 chk("boot_req", imem.req, 0);
        @(negedge clk);
        chk("first_req", imem.req, 1);
        chk("first_addr", imem.addr, 32'h0);
        @(negedge clk);
        chk("wait_req_low", imem.req, 0);
        chk("wait_if_valid", if_valid, 0);
        @(negedge clk);
        chk("first_if_valid", if_valid, 1);
        chk("first_if_pc", if_pc, 32'h0);
        chk("first_if_instr", if_instr, 32'h0010_0093);
        chk("second_addr", imem.addr, 32'h4);
        chk("second_req", imem.req, 1);

        // Redirect in the same cycle REQ is accepted at 0x8
        wait_req(1'b1, 32'h8, ok);
        chk("reach_req_8", ok, 1);
        drive_ex(1'b1, 3'b001, 32'hE0, 32'h20, 32'h0);
        #1 chk("req_redir_flush", ifid_flush, 1);
        chk("req_redir_idex", idex_flush, 1);
        @(negedge clk);
        drive_ex(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        #1 chk("flush_pulse_end", ifid_flush, 0);
        chk("discard_req", imem.req, 0);
        chk("discard_if_valid", if_valid, 0);
        @(negedge clk);
        chk("after_discard_req", imem.req, 1);
        chk("after_discard_addr", imem.addr, 32'h100);
        for (int i = 0; i < 10 && !if_valid; i++) @(negedge clk);
        chk("redir_first_pc", if_pc, 32'h100);
        chk("redir_first_instr", if_instr, instr_of(32'h100));

        // Jump to 0x10, then stall while 0x14 lands in the buffer
        wait_req(1'b0, 32'h0, ok);
        drive_ex(1'b1, 3'b010, 32'h0, 32'h10, 32'h0);
        @(negedge clk);
        drive_ex(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        wait_if(32'h10, ok);
        chk("reach_if_10", ok, 1);
        chk("stall_pre_req", imem.req, 1);
        chk("stall_pre_addr", imem.addr, 32'h14);
        hazard_stall = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("stall_full_req", imem.req, 0);
        chk("stall_hold_pc1", if_pc, 32'h10);
        chk("stall_hold_valid", if_valid, 1);
        @(negedge clk);
        chk("stall_full_req2", imem.req, 0);
        chk("stall_hold_pc2", if_pc, 32'h10);
        hazard_stall = 1'b0;
        @(negedge clk);
        chk("release_if_pc", if_pc, 32'h14);
        chk("release_if_instr", if_instr, instr_of(32'h14));
        chk("release_if_valid", if_valid, 1);
        chk("release_req_addr", imem.addr, 32'h18);

        // Redirect in REQ without ready: stay in REQ with the new pc
        wait_req(1'b0, 32'h0, ok);
        mem_ready = 1'b0;
        drive_ex(1'b1, 3'b011, 32'h0, 32'h0, 32'h301);
        @(negedge clk);
        drive_ex(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        chk("noready_req", imem.req, 1);
        chk("noready_addr", imem.addr, 32'h300);
        mem_ready = 1'b1;

        // Table: next-PC decision applied in WAIT while the response is arriving
        for (int i = 0; i < 9; i++) begin
            wait_req(1'b0, 32'h0, ok);
            chk("vec_sync", ok, 1);
            a = imem.addr;
            @(negedge clk);
            drive_ex(vec[i].v, vec[i].op, vec[i].p, vec[i].imm, vec[i].alu);
            addr_q.push_back(vec[i].exp_flush ? vec[i].exp_target : a + 32'h4);
            #1 chk($sformatf("vec%0d_flush", i), ifid_flush, vec[i].exp_flush);
            @(negedge clk);
            drive_ex(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
            chk($sformatf("vec%0d_if_valid", i), if_valid, !vec[i].exp_flush);
            wait_req(1'b0, 32'h0, ok);
            chk($sformatf("vec%0d_next_req", i), ok, 1);
            chk($sformatf("vec%0d_next_addr", i), imem.addr, addr_q.pop_front());
        end

        // One instruction every two cycles
        wait_req(1'b0, 32'h0, ok);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem.req && imem.ready) cnt++;
            @(negedge clk);
        end
        chk("throughput", cnt, 10);

        // Reset asserted while waiting for a response
        wait_req(1'b0, 32'h0, ok);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midrst_req", imem.req, 0);
        chk("midrst_addr", imem.addr, 32'h0);
        chk("midrst_if_valid", if_valid, 0);
        chk("midrst_if_pc", if_pc, 32'h0);
        chk("midrst_if_instr", if_instr, 32'h0000_0013);
        chk("midrst_flush", ifid_flush, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
